led_pwm_fader: RTL

Parametrised multi-channel PWM dimmer for discrete LED filaments. It drives N channels of configurable value width from flat target vectors. Each channel has an optional linear fade toward its target, optional phase-staggered PWM periods to spread switching current, and selectable output polarity. It sits between the display/palette logic and the LED pins, and is the next-generation replacement for the fixed 8-bit, fixed-4-LED-group PWM driver.

---
 rtl/led_pwm_fader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/led_pwm_fader.sv
// Multi-channel PWM dimmer for LED filaments: per-channel linear fade toward a
// target level, optional phase-staggered periods and selectable output polarity.
module led_pwm_fader #(
    parameter int parm_channel_count           = 16,
    parameter int parm_value_width             = 8,
    parameter int parm_FCLK                    = 40_000_000,
    parameter int parm_pwm_period_milliseconds = 10,
    parameter int parm_max_duty_percent        = 80,
    parameter int parm_phase_stagger           = 1,
    parameter int parm_active_high             = 1
) (
    input  logic                                          i_clk,
    input  logic                                          i_arst,
    input  logic [parm_channel_count*parm_value_width-1:0] i_target_values,
    input  logic                                          i_fade_enable,
    input  logic [parm_value_width-1:0]                   i_fade_step,
    output logic [parm_channel_count-1:0]                 eo_pwm,
    output logic [parm_channel_count-1:0]                 o_fade_busy,
    output logic                                          o_period_strobe
);

    localparam int N       = parm_channel_count;
    localparam int W       = parm_value_width;
    localparam int P       = parm_FCLK / 1000 * parm_pwm_period_milliseconds;
    localparam int M       = P / 100 * parm_max_duty_percent;
    localparam int R       = M / ((1 << W) - 1);
    localparam int CW      = (P > 1) ? $clog2(P) : 1;
    localparam int PW      = $clog2(P + 1);
    localparam int STEP    = P / N;
    localparam bit STAGGER = (parm_phase_stagger != 0);
    localparam bit AH      = (parm_active_high != 0);
    localparam logic [CW-1:0] LAST = CW'(P - 1);

    if (R < 1) begin : g_bad_ratio
        $error("led_pwm_fader: duty ceiling too small for the level width (R < 1)");
    end
    if (STAGGER && (P < N)) begin : g_bad_stagger
        $error("led_pwm_fader: PWM period shorter than channel count with staggering");
    end

    logic [CW-1:0] cnt_q   [N];
    logic [CW-1:0] cnt_d   [N];
    logic [W-1:0]  level_q [N];
    logic [W-1:0]  level_d [N];
    logic [W-1:0]  tgt_q   [N];
    logic [W-1:0]  tgt_d   [N];
    logic [PW-1:0] prod_q  [N];
    logic [PW-1:0] prod_d  [N];
    logic [PW-1:0] duty_q  [N];
    logic [PW-1:0] duty_d  [N];
    logic [N-1:0]  pwm_q;
    logic [N-1:0]  pwm_d;
    logic [N-1:0]  busy_q;
    logic [N-1:0]  busy_d;
    logic          strobe_q;
    logic          strobe_d;

    function automatic logic [CW-1:0] cnt_init(input int k);
        return STAGGER ? CW'(k * STEP) : '0;
    endfunction

    // Unsigned step toward the target that lands exactly on it instead of overshooting.
    function automatic logic [W-1:0] fade_next(input logic [W-1:0] level,
                                               input logic [W-1:0] tgt,
                                               input logic [W-1:0] step);
        logic [W-1:0] diff;
        if (tgt >= level) begin
            diff = tgt - level;
            return (diff <= step) ? tgt : level + step;
        end
        diff = level - tgt;
        return (diff <= step) ? tgt : level - step;
    endfunction

    always_comb begin
        for (int k = 0; k < N; k++) begin
            tgt_d[k]   = i_target_values[k*W +: W];
            prod_d[k]  = PW'(R * int'(level_q[k]));
            cnt_d[k]   = cnt_q[k] + CW'(1);
            level_d[k] = level_q[k];
            duty_d[k]  = duty_q[k];
            if (cnt_q[k] == LAST) begin
                cnt_d[k]  = '0;
                // prod still holds the pre-update level, so duty lags level by one period.
                duty_d[k] = prod_q[k];
                if (i_fade_enable) begin
                    level_d[k] = fade_next(level_q[k], tgt_q[k], i_fade_step);
                end else begin
                    level_d[k] = tgt_q[k];
                end
            end
            pwm_d[k]  = (PW'(cnt_q[k]) < duty_q[k]) ~^ AH;
            busy_d[k] = (level_q[k] != tgt_q[k]);
        end
        strobe_d = (cnt_q[0] == LAST);
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            for (int k = 0; k < N; k++) begin
                cnt_q[k]   <= cnt_init(k);
                level_q[k] <= '0;
                tgt_q[k]   <= '0;
                prod_q[k]  <= '0;
                duty_q[k]  <= '0;
            end
            pwm_q    <= {N{~AH}};
            busy_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                cnt_q[k]   <= cnt_d[k];
                level_q[k] <= level_d[k];
                tgt_q[k]   <= tgt_d[k];
                prod_q[k]  <= prod_d[k];
                duty_q[k]  <= duty_d[k];
            end
            pwm_q    <= pwm_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
        end
    end

    assign eo_pwm          = pwm_q;
    assign o_fade_busy     = busy_q;
    assign o_period_strobe = strobe_q;

endmodule
